// File: rtl/s_axis_cc_arbiter.sv
// Two-requester, packet-atomic round-robin arbiter merging two AXI-Stream
// completer-completion sources onto one master stream, with per-requester packet counters.
module s_axis_cc_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    user_clk,
  input  logic                    user_reset_n,
  input  logic [1:0]              s_axis_cc_tvalid,
  output logic [1:0]              s_axis_cc_tready,
  input  logic [1:0]              s_axis_cc_tlast,
  input  logic [2*DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [2*KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic [7:0]              s_axis_cc_tuser,
  output logic                    m_axis_cc_tvalid,
  input  logic                    m_axis_cc_tready,
  output logic                    m_axis_cc_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_cc_tkeep,
  output logic [3:0]              m_axis_cc_tuser,
  output logic [1:0]              grant,
  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        sel;
  logic        busy;
  logic        last_hs;

  // grant_q is one-hot while BUSY, so bit 1 alone names the owner
  assign sel  = grant_q[1];
  assign busy = (state_q == BUSY);

  always_comb begin
    m_axis_cc_tvalid = busy & s_axis_cc_tvalid[sel];
    m_axis_cc_tlast  = s_axis_cc_tlast[sel];
    m_axis_cc_tdata  = sel ? s_axis_cc_tdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : s_axis_cc_tdata[DATA_WIDTH-1:0];
    m_axis_cc_tkeep  = sel ? s_axis_cc_tkeep[2*KEEP_WIDTH-1:KEEP_WIDTH]
                           : s_axis_cc_tkeep[KEEP_WIDTH-1:0];
    m_axis_cc_tuser  = sel ? s_axis_cc_tuser[7:4] : s_axis_cc_tuser[3:0];
    s_axis_cc_tready = (busy && m_axis_cc_tready) ? grant_q : '0;
  end

  assign last_hs = m_axis_cc_tvalid & m_axis_cc_tready & m_axis_cc_tlast;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (state_q == IDLE) begin
      if (|s_axis_cc_tvalid) begin
        state_d = BUSY;
        // On a tie the requester that did not own the last packet wins
        if (&s_axis_cc_tvalid) grant_d = last_owner_q ? 2'b01 : 2'b10;
        else                   grant_d = s_axis_cc_tvalid;
      end
    end else if (last_hs) begin
      state_d      = IDLE;
      grant_d      = '0;
      last_owner_d = sel;
      if (sel) cnt1_d = cnt1_q + 16'd1;
      else     cnt0_d = cnt0_q + 16'd1;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign grant    = grant_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Self-checking bench for s_axis_cc_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a packet-level reference model.
module tb_s_axis_cc_arbiter;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    tvalid = '0, tlast = '0;
  logic [2*DW-1:0] tdata = '0;
  logic [2*KW-1:0] tkeep = '0;
  logic [7:0]    tuser = '0;
  logic          mready = 1'b0;
  logic [1:0]    s_tready, grant;
  logic          m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [3:0]    m_tuser;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  s_axis_cc_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .user_clk(clk), .user_reset_n(rst_n),
    .s_axis_cc_tvalid(tvalid), .s_axis_cc_tready(s_tready),
    .s_axis_cc_tlast(tlast), .s_axis_cc_tdata(tdata),
    .s_axis_cc_tkeep(tkeep), .s_axis_cc_tuser(tuser),
    .m_axis_cc_tvalid(m_tvalid), .m_axis_cc_tready(mready),
    .m_axis_cc_tlast(m_tlast), .m_axis_cc_tdata(m_tdata),
    .m_axis_cc_tkeep(m_tkeep), .m_axis_cc_tuser(m_tuser),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit do_chk  = 1'b1;

  // Packet-level model: who owns the stream, who owned it last, packets per requester
  bit          m_busy;
  int          m_owner, m_last;
  logic [15:0] m_cnt [2];

  logic [1:0]    cap_grant, cap_sr;
  logic          cap_mv;
  logic [DW-1:0] cap_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 1;
    m_cnt[0] = '0; m_cnt[1] = '0;
  endtask

  task automatic tick();
    logic [1:0] eg, esr;
    logic emv;
    @(negedge clk);
    cap_grant = grant; cap_mv = m_tvalid; cap_sr = s_tready; cap_data = m_tdata;
    eg = '0; esr = '0; emv = 1'b0;
    if (m_busy) begin
      eg  = 2'b01 << m_owner;
      emv = tvalid[m_owner];
      if (mready) esr = eg;
    end
    if (do_chk) begin
      chk("grant", grant, eg);
      chk("m_tvalid", m_tvalid, emv);
      chk("s_tready", s_tready, esr);
      chk("pkt_cnt0", pkt_cnt0, m_cnt[0]);
      chk("pkt_cnt1", pkt_cnt1, m_cnt[1]);
      if (emv) begin
        chk("m_tdata", m_tdata, tdata[m_owner*DW +: DW]);
        chk("m_tkeep", m_tkeep, tkeep[m_owner*KW +: KW]);
        chk("m_tuser", m_tuser, tuser[m_owner*4 +: 4]);
        chk("m_tlast", m_tlast, tlast[m_owner]);
      end
    end
    @(posedge clk);
    if (!m_busy) begin
      if (tvalid != 2'b00) begin
        m_busy = 1'b1;
        if (tvalid == 2'b11) m_owner = 1 - m_last;
        else                 m_owner = tvalid[1] ? 1 : 0;
      end
    end else if (tvalid[m_owner] && mready && tlast[m_owner]) begin
      m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
      m_last = m_owner;
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid = '0; tlast = '0; mready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] tv, tl;
    logic       mr;
    logic [1:0] eg;
    logic       emv;
    logic [1:0] esr;
  } vec_t;

  vec_t vt [9];
  logic [DW-1:0] rx [$];
  int hs_cyc [$];

  initial begin
    int b, drops, stalled;
    model_reset();

    // Both requesters, 3-beat packets each: 0 first, one IDLE cycle, then 1
    vt[0] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    vt[1] = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01};
    vt[2] = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01};
    vt[3] = '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    vt[4] = '{2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    vt[5] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10};
    vt[6] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10};
    vt[7] = '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    vt[8] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tvalid = vt[i].tv; tlast = vt[i].tl; mready = vt[i].mr;
      tdata = {32'hB000_0000 + i, 32'hA000_0000 + i};
      tkeep = 8'h3F; tuser = 8'h21;
      tick();
      chk($sformatf("vec%0d_grant", i), cap_grant, vt[i].eg);
      chk($sformatf("vec%0d_mvalid", i), cap_mv, vt[i].emv);
      chk($sformatf("vec%0d_sready", i), cap_sr, vt[i].esr);
    end
    chk("vec_cnt0", pkt_cnt0, 16'd1);
    chk("vec_cnt1", pkt_cnt1, 16'd1);

    // Requester 1 alone, three single-beat packets back to back
    do_reset();
    tvalid = 2'b10; tlast = 2'b10; mready = 1'b1; tdata = {32'hCAFE_0001, 32'h0};
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cap_mv) hs_cyc.push_back(c);
    end
    tvalid = '0;
    tick();
    chk("r1_beats", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("r1_gap1", hs_cyc[1] - hs_cyc[0], 2);
      chk("r1_gap2", hs_cyc[2] - hs_cyc[1], 2);
    end
    chk("r1_cnt1", pkt_cnt1, 16'd3);

    // 4-beat req0 packet under toggling ready, req1 waiting throughout
    do_reset();
    b = 0; rx.delete();
    for (int c = 0; c < 40 && b < 4; c++) begin
      tvalid = 2'b11; mready = c[0];
      tlast = {1'b1, (b == 3)};
      tdata = {32'hB0, 32'hA0 + b};
      tick();
      chk("tog_sready1", cap_sr[1], 1'b0);
      if (cap_mv && mready) begin rx.push_back(cap_data); b++; end
    end
    chk("tog_done", b, 4);
    for (int i = 0; i < rx.size(); i++) chk("tog_order", rx[i], 32'hA0 + i);
    mready = 1'b1; tvalid = 2'b10;
    repeat (3) tick();
    chk("tog_cnt", {pkt_cnt1, pkt_cnt0}, 32'h0001_0001);

    // Req0 drops tvalid for 5 cycles mid-packet
    do_reset();
    b = 0; drops = 0; stalled = 0; rx.delete(); mready = 1'b1;
    for (int c = 0; c < 40 && b < 4; c++) begin
      if (b == 2 && drops < 5) begin tvalid = 2'b00; drops++; end
      else tvalid = 2'b01;
      tlast = {1'b0, (b == 3)}; tdata = {32'h0, 32'hD0 + b};
      tick();
      if (cap_grant == 2'b01 && !cap_mv) stalled++;
      if (cap_mv) begin rx.push_back(cap_data); b++; end
    end
    chk("drop_stall", stalled, 5);
    chk("drop_done", b, 4);
    for (int i = 0; i < rx.size(); i++) chk("drop_order", rx[i], 32'hD0 + i);
    tvalid = '0;
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tvalid = 2'($urandom); tlast = 2'($urandom); mready = 1'($urandom);
      tdata = {$urandom, $urandom}; tkeep = 8'($urandom); tuser = 8'($urandom);
      tick();
    end

    // pkt_cnt0 wrap after 65536 single-beat packets
    do_reset();
    do_chk = 1'b0;
    tvalid = 2'b01; tlast = 2'b01; mready = 1'b1;
    repeat (131070) tick();
    chk("wrap_ffff", pkt_cnt0, 16'hFFFF);
    repeat (2) tick();
    chk("wrap_zero", pkt_cnt0, 16'h0000);
    do_chk = 1'b1;
    tvalid = '0;
    tick();

    // Reset asserted on beat 2 of 4, then a tie after release
    do_reset();
    b = 0; mready = 1'b1;
    for (int c = 0; c < 10 && b < 2; c++) begin
      tvalid = 2'b11; tlast = 2'b00; tdata = {32'hB0, 32'hE0 + b};
      tick();
      if (cap_mv) b++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_sready", s_tready, 2'b00);
    chk("rst_cnt", {pkt_cnt1, pkt_cnt0}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    tvalid = 2'b11; tlast = 2'b00;
    tick();
    tick();
    chk("rst_tie_grant", cap_grant, 2'b01);
    tvalid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
